baby_mem_bridge: RTL and testbench
==================================

Name: baby_mem_bridge

Overview:
- Memory-side responder for the Manchester Baby core's RAM port; serves the core's 32-word x 32-bit store access requests.
- Each request is serialised as a byte-wide transfer over an external 8-bit handshake bus to an off-chip store.
- Owns the core's clock-enable (drives the core's clock_toggle input) and halts the core while a transfer is in flight.
- Sits at chip top, between the core wrapper and the I/O pins.

Parameters:
- TIMEOUT_CYCLES, 255, max idle cycles waiting on a single external handshake before abort; 0 disables the timeout.
- TO_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^TO_W.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- mem_req_i  in  1  core requests a store access this cycle.
- ram_addr_i  in  5  word address from core.
- ram_rw_en_i  in  1  0 = read, 1 = write.
- ram_data_i  in  32  write data from core.
- ram_data_o  out  32  read data to core.
- baby_run_o  out  1  clock enable to the core (ANDed with clock upstream).
- ext_data_o  out  8  outbound byte.
- ext_valid_o  out  1  outbound byte valid.
- ext_ready_i  in  1  off-chip store accepts outbound byte.
- ext_data_i  in  8  inbound read byte.
- ext_valid_i  in  1  inbound byte valid; the bridge is always ready in RD_BYTE.
- busy_o  out  1  high in any state other than IDLE.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset values (reset_i high at a clock edge): state=IDLE, ram_data_o=0, ext_data_o=0, ext_valid_o=0, err_o=0, byte index=0, timeout counter=0. Reset aborts any transfer immediately; a partially assembled read word is discarded.
- baby_run_o is combinational: 1 when (state==IDLE and mem_req_i==0) or state==DONE; 0 otherwise. The core therefore freezes in the same cycle a request is seen.
- States: IDLE, HDR, WR_BYTE, RD_BYTE, DONE.
- IDLE: on mem_req_i=1, latch addr, rw and write data, then go to HDR. No request means no change.
- HDR: ext_data_o = {rw, 2'b00, addr[4:0]}; ext_valid_o=1. On ext_valid_o & ext_ready_i, go to WR_BYTE if rw=1, else RD_BYTE; byte index=0.
- WR_BYTE: ext_data_o = latched data byte[index], LSB first; ext_valid_o=1. Each accepted handshake increments index. On acceptance of index 3, go to DONE.
- RD_BYTE: ext_valid_o=0. Each cycle with ext_valid_i=1 shifts ext_data_i into byte[index] of an assembly register and increments index. On the 4th byte, write the assembled word to ram_data_o in the same edge and go to DONE.
- ram_data_o changes only on read completion, read timeout, or reset; it holds across writes.
- DONE: baby_run_o=1 for exactly one cycle, then IDLE. A mem_req_i asserted in DONE is ignored; the core must re-present it in IDLE.
- ext_valid_o drops in the cycle after the final handshake. ext_data_o is stable while ext_valid_o=1 and ext_ready_i=0.
- Timeout: the counter clears on every handshake and on state entry, and increments in HDR, WR_BYTE and RD_BYTE when no handshake occurs. On reaching TIMEOUT_CYCLES (if nonzero): set err_o, drop ext_valid_o, set ram_data_o=0 if the access is a read, go to DONE. err_o clears only on reset.
- Latency with zero-wait external bus: write = 1 + 1 + 4 + 1 cycles from request to resume (request cycle + HDR + 4 bytes + DONE). Read is the same when ext_valid_i is high every cycle.

Test Plan:
- Write: mem_req_i, rw=1, addr=5, data=0xDEADBEEF, ext_ready_i=1 -> bytes 0x85,0xEF,0xBE,0xAD,0xDE on consecutive cycles; baby_run_o low 6 cycles, high in DONE.
- Read: rw=0, addr=31; ext returns 0x11,0x22,0x33,0x44 -> header 0x1F; ram_data_o=0x44332211 from DONE onward; it stays unchanged after a following write.
- Backpressure: ext_ready_i low for 3 cycles on byte 2 of a write -> ext_data_o holds 0xAD, no byte skipped or duplicated, busy_o high throughout.
- Timeout: TIMEOUT_CYCLES=4, read with no ext_valid_i -> after 4 idle cycles err_o=1, ram_data_o=0, DONE, core resumes; err_o stays 1 through later good accesses.
- Reset mid-read after 2 bytes -> next cycle IDLE, ram_data_o=0, ext_valid_o=0, baby_run_o=1; a fresh read completes correctly.
- Back-to-back: mem_req_i held high through DONE -> exactly one new transaction starts from the following IDLE cycle, not two.

Source files
------------

// File: rtl/baby_mem_bridge_if.sv
// baby_mem_bridge_if
// Byte-wide handshake bus between the Baby memory bridge and the off-chip store.
//   ext_data_o  / ext_valid_o : outbound byte and its valid, driven by the bridge
//   ext_ready_i               : the off-chip store accepts the outbound byte
//   ext_data_i  / ext_valid_i : inbound read byte and its valid, driven by the store
// The master modport is the bridge side. The slave modport is the off-chip store side.
interface baby_mem_bridge_if;
    logic [7:0] ext_data_o;
    logic       ext_valid_o;
    logic       ext_ready_i;
    logic [7:0] ext_data_i;
    logic       ext_valid_i;

    modport master (
        output ext_data_o,
        output ext_valid_o,
        input  ext_ready_i,
        input  ext_data_i,
        input  ext_valid_i
    );

    modport slave (
        input  ext_data_o,
        input  ext_valid_o,
        output ext_ready_i,
        output ext_data_i,
        output ext_valid_i
    );
endinterface

// File: rtl/baby_mem_bridge.sv
// baby_mem_bridge
// Serves the Manchester Baby core's 32 x 32-bit store port. Each access is
// serialised over a byte-wide handshake bus to an off-chip store. The bridge
// holds the core's clock enable low while a transfer is in flight.
// Ports:
//   clock, reset_i     : system clock; synchronous active-high reset
//   mem_req_i          : the core requests a store access
//   ram_addr_i         : word address from the core
//   ram_rw_en_i        : 0 = read, 1 = write
//   ram_data_i         : write data from the core
//   ram_data_o         : read data returned to the core
//   baby_run_o         : clock enable to the core
//   busy_o             : high whenever the FSM is not in IDLE
//   err_o              : sticky handshake-timeout flag
//   ext                : external byte bus (master side)
module baby_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic                clock,
    input  logic                reset_i,
    input  logic                mem_req_i,
    input  logic [4:0]          ram_addr_i,
    input  logic                ram_rw_en_i,
    input  logic [31:0]         ram_data_i,
    output logic [31:0]         ram_data_o,
    output logic                baby_run_o,
    output logic                busy_o,
    output logic                err_o,
    baby_mem_bridge_if.master   ext
);

    typedef enum logic [2:0] {IDLE, HDR, WR_BYTE, RD_BYTE, DONE} state_t;

    localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t          state;
    state_t          next_state;
    logic [4:0]      addr_q;
    logic            rw_q;
    logic [31:0]     wdata_q;
    logic [23:0]     asm_q;
    logic [1:0]      byte_idx;
    logic [TO_W-1:0] to_cnt;
    logic            handshake;
    logic            in_xfer;
    logic            timed_out;

    // State register. Reset drops any transfer in flight straight back to IDLE.
    always_ff @(posedge clock) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and bus outputs. A timeout is raised in the cycle that would
    // otherwise be the TIMEOUT_CYCLES-th cycle without a handshake, so the
    // FSM is in DONE right after that many idle cycles.
    always_comb begin
        next_state      = state;
        ext.ext_valid_o = 1'b0;
        ext.ext_data_o  = 8'h00;
        handshake       = 1'b0;
        in_xfer         = 1'b0;
        timed_out       = 1'b0;

        case (state)
            IDLE: begin
                if (mem_req_i) begin
                    next_state = HDR;
                end
            end
            HDR: begin
                in_xfer         = 1'b1;
                ext.ext_valid_o = 1'b1;
                ext.ext_data_o  = {rw_q, 2'b00, addr_q};
                handshake       = ext.ext_ready_i;
                if (handshake) begin
                    next_state = rw_q ? WR_BYTE : RD_BYTE;
                end
            end
            WR_BYTE: begin
                in_xfer         = 1'b1;
                ext.ext_valid_o = 1'b1;
                ext.ext_data_o  = wdata_q[{byte_idx, 3'b000} +: 8];
                handshake       = ext.ext_ready_i;
                if (handshake && byte_idx == 2'd3) begin
                    next_state = DONE;
                end
            end
            RD_BYTE: begin
                in_xfer   = 1'b1;
                handshake = ext.ext_valid_i;
                if (handshake && byte_idx == 2'd3) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (TO_EN && in_xfer && !handshake && to_cnt == TO_LAST) begin
            timed_out  = 1'b1;
            next_state = DONE;
        end
    end

    // The core keeps running while idle with no request and for the single
    // DONE cycle; it freezes in the very cycle a request appears.
    assign baby_run_o = (state == IDLE && !mem_req_i) || state == DONE;
    assign busy_o     = (state != IDLE);

    // Datapath: request latch, byte index, read assembly, timeout counter and
    // the returned read word. ram_data_o only moves on read completion, read
    // timeout or reset, so it holds its value across writes.
    always_ff @(posedge clock) begin
        if (reset_i) begin
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            asm_q      <= '0;
            byte_idx   <= '0;
            to_cnt     <= '0;
            ram_data_o <= '0;
            err_o      <= 1'b0;
        end else begin
            if (state == IDLE && mem_req_i) begin
                addr_q  <= ram_addr_i;
                rw_q    <= ram_rw_en_i;
                wdata_q <= ram_data_i;
                to_cnt  <= '0;
            end

            if (timed_out) begin
                err_o  <= 1'b1;
                to_cnt <= '0;
                if (!rw_q) begin
                    ram_data_o <= '0;
                end
            end else if (handshake) begin
                to_cnt <= '0;
                case (state)
                    HDR: begin
                        byte_idx <= '0;
                    end
                    WR_BYTE: begin
                        byte_idx <= byte_idx + 2'd1;
                    end
                    RD_BYTE: begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    asm_q[7:0]   <= ext.ext_data_i;
                            2'd1:    asm_q[15:8]  <= ext.ext_data_i;
                            2'd2:    asm_q[23:16] <= ext.ext_data_i;
                            default: ram_data_o   <= {ext.ext_data_i, asm_q};
                        endcase
                    end
                    default: begin
                    end
                endcase
            end else if (in_xfer) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_baby_mem_bridge.sv
// tb_baby_mem_bridge
// Directed bench for baby_mem_bridge with a 4-cycle handshake timeout.
// Inputs are driven just after each rising edge and outputs are sampled a
// moment later, well before the next edge.
module tb_baby_mem_bridge;

    logic        clock = 1'b0;
    logic        reset_i;
    logic        mem_req_i;
    logic [4:0]  ram_addr_i;
    logic        ram_rw_en_i;
    logic [31:0] ram_data_i;
    logic [31:0] ram_data_o;
    logic        baby_run_o;
    logic        busy_o;
    logic        err_o;

    int check_count = 0;
    int error_count = 0;

    baby_mem_bridge_if bus ();

    baby_mem_bridge #(
        .TIMEOUT_CYCLES (4),
        .TO_W           (3)
    ) dut (
        .clock       (clock),
        .reset_i     (reset_i),
        .mem_req_i   (mem_req_i),
        .ram_addr_i  (ram_addr_i),
        .ram_rw_en_i (ram_rw_en_i),
        .ram_data_i  (ram_data_i),
        .ram_data_o  (ram_data_o),
        .baby_run_o  (baby_run_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .ext         (bus.master)
    );

    always #5 clock = ~clock;

    // Counts one comparison and reports it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives every non-reset input for the current cycle and lets it settle.
    task automatic applyStimulus(input logic req, input logic rw, input logic [4:0] addr,
                                 input logic [31:0] wdata, input logic ready,
                                 input logic vin, input logic [7:0] din);
        mem_req_i       = req;
        ram_rw_en_i     = rw;
        ram_addr_i      = addr;
        ram_data_i      = wdata;
        bus.ext_ready_i = ready;
        bus.ext_valid_i = vin;
        bus.ext_data_i  = din;
        #1;
    endtask

    task automatic waitCycle();
        @(posedge clock);
        #1;
    endtask

    // Full write starting in the current IDLE cycle, ending in the following
    // IDLE cycle. Byte stall_idx sees stall_n cycles of ready low first.
    // With hold set the request stays high all the way through.
    task automatic doWrite(input logic [4:0] addr, input logic [31:0] data,
                           input int stall_idx, input int stall_n, input logic hold);
        logic [7:0] exp_byte;
        applyStimulus(1'b1, 1'b1, addr, data, 1'b1, 1'b0, 8'h00);
        checkOutput("wr_req_run", baby_run_o, 0);
        checkOutput("wr_req_busy", busy_o, 0);
        waitCycle();
        applyStimulus(hold, 1'b1, addr, data, 1'b1, 1'b0, 8'h00);
        checkOutput("wr_hdr_data", bus.ext_data_o, {24'h0, 1'b1, 2'b00, addr});
        checkOutput("wr_hdr_valid", bus.ext_valid_o, 1);
        checkOutput("wr_hdr_run", baby_run_o, 0);
        for (int i = 0; i < 4; i++) begin
            exp_byte = data[i*8 +: 8];
            waitCycle();
            for (int s = 0; s < ((i == stall_idx) ? stall_n : 0); s++) begin
                applyStimulus(hold, 1'b1, addr, data, 1'b0, 1'b0, 8'h00);
                checkOutput("wr_stall_data", bus.ext_data_o, {24'h0, exp_byte});
                checkOutput("wr_stall_valid", bus.ext_valid_o, 1);
                checkOutput("wr_stall_busy", busy_o, 1);
                waitCycle();
            end
            applyStimulus(hold, 1'b1, addr, data, 1'b1, 1'b0, 8'h00);
            checkOutput("wr_byte_data", bus.ext_data_o, {24'h0, exp_byte});
            checkOutput("wr_byte_valid", bus.ext_valid_o, 1);
            checkOutput("wr_byte_run", baby_run_o, 0);
        end
        waitCycle();
        applyStimulus(hold, 1'b1, addr, data, 1'b1, 1'b0, 8'h00);
        checkOutput("wr_done_run", baby_run_o, 1);
        checkOutput("wr_done_valid", bus.ext_valid_o, 0);
        checkOutput("wr_done_busy", busy_o, 1);
        waitCycle();
        applyStimulus(hold, 1'b1, addr, data, 1'b1, 1'b0, 8'h00);
        checkOutput("wr_idle_busy", busy_o, 0);
        checkOutput("wr_idle_run", baby_run_o, !hold);
    endtask

    // Full read with the store returning one byte per cycle, LSB first.
    task automatic doRead(input logic [4:0] addr, input logic [31:0] word);
        applyStimulus(1'b1, 1'b0, addr, 32'h0, 1'b1, 1'b0, 8'h00);
        checkOutput("rd_req_run", baby_run_o, 0);
        waitCycle();
        applyStimulus(1'b0, 1'b0, addr, 32'h0, 1'b1, 1'b0, 8'h00);
        checkOutput("rd_hdr_data", bus.ext_data_o, {27'h0, addr});
        checkOutput("rd_hdr_valid", bus.ext_valid_o, 1);
        for (int i = 0; i < 4; i++) begin
            waitCycle();
            applyStimulus(1'b0, 1'b0, addr, 32'h0, 1'b1, 1'b1, word[i*8 +: 8]);
            checkOutput("rd_byte_valid_o", bus.ext_valid_o, 0);
            checkOutput("rd_byte_run", baby_run_o, 0);
        end
        waitCycle();
        applyStimulus(1'b0, 1'b0, addr, 32'h0, 1'b1, 1'b0, 8'h00);
        checkOutput("rd_done_data", ram_data_o, word);
        checkOutput("rd_done_run", baby_run_o, 1);
        waitCycle();
        applyStimulus(1'b0, 1'b0, addr, 32'h0, 1'b1, 1'b0, 8'h00);
        checkOutput("rd_idle_busy", busy_o, 0);
        checkOutput("rd_idle_data", ram_data_o, word);
    endtask

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", check_count, error_count + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios: reset, write, read, backpressure, timeout,
    // reset mid-read and back-to-back requests.
    initial begin
        reset_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 8'h00);
        waitCycle();
        waitCycle();
        reset_i = 1'b0;
        #1;
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_run", baby_run_o, 1);
        checkOutput("rst_valid", bus.ext_valid_o, 0);
        checkOutput("rst_ext_data", bus.ext_data_o, 0);
        checkOutput("rst_ram_data", ram_data_o, 0);
        checkOutput("rst_err", err_o, 0);

        $display("[TB] plain write");
        doWrite(5'd5, 32'hDEADBEEF, -1, 0, 1'b0);

        $display("[TB] plain read then write");
        doRead(5'd31, 32'h44332211);
        doWrite(5'd2, 32'h01020304, -1, 0, 1'b0);
        checkOutput("rd_hold_after_wr", ram_data_o, 32'h44332211);

        $display("[TB] backpressure on byte 2");
        doWrite(5'd5, 32'hDEADBEEF, 2, 3, 1'b0);
        checkOutput("bp_err", err_o, 0);

        $display("[TB] read timeout");
        applyStimulus(1'b1, 1'b0, 5'd7, 32'h0, 1'b1, 1'b0, 8'h00);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 5'd7, 32'h0, 1'b1, 1'b0, 8'h00);
        checkOutput("to_hdr_data", bus.ext_data_o, 32'h07);
        for (int i = 0; i < 4; i++) begin
            waitCycle();
            applyStimulus(1'b0, 1'b0, 5'd7, 32'h0, 1'b1, 1'b0, 8'h00);
            checkOutput("to_wait_busy", busy_o, 1);
            checkOutput("to_wait_err", err_o, 0);
            checkOutput("to_wait_run", baby_run_o, 0);
        end
        waitCycle();
        applyStimulus(1'b0, 1'b0, 5'd7, 32'h0, 1'b1, 1'b0, 8'h00);
        checkOutput("to_done_err", err_o, 1);
        checkOutput("to_done_data", ram_data_o, 0);
        checkOutput("to_done_run", baby_run_o, 1);
        checkOutput("to_done_busy", busy_o, 1);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 5'd7, 32'h0, 1'b1, 1'b0, 8'h00);
        checkOutput("to_idle_busy", busy_o, 0);
        doWrite(5'd9, 32'h12345678, -1, 0, 1'b0);
        checkOutput("to_err_sticky_wr", err_o, 1);
        doRead(5'd1, 32'hA1B2C3D4);
        checkOutput("to_err_sticky_rd", err_o, 1);

        $display("[TB] reset mid-read");
        applyStimulus(1'b1, 1'b0, 5'd9, 32'h0, 1'b1, 1'b0, 8'h00);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 5'd9, 32'h0, 1'b1, 1'b0, 8'h00);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 5'd9, 32'h0, 1'b1, 1'b1, 8'h55);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 5'd9, 32'h0, 1'b1, 1'b1, 8'h66);
        waitCycle();
        reset_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'd9, 32'h0, 1'b1, 1'b0, 8'h00);
        checkOutput("mr_pre_busy", busy_o, 1);
        waitCycle();
        reset_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd9, 32'h0, 1'b1, 1'b0, 8'h00);
        checkOutput("mr_busy", busy_o, 0);
        checkOutput("mr_ram_data", ram_data_o, 0);
        checkOutput("mr_valid", bus.ext_valid_o, 0);
        checkOutput("mr_run", baby_run_o, 1);
        checkOutput("mr_err", err_o, 0);
        doRead(5'd9, 32'h04030201);

        $display("[TB] back-to-back requests");
        doWrite(5'd3, 32'hCAFEF00D, -1, 0, 1'b1);
        doWrite(5'd4, 32'h0BADC0DE, -1, 0, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 8'h00);
        checkOutput("b2b_idle_busy", busy_o, 0);
        checkOutput("b2b_idle_valid", bus.ext_valid_o, 0);
        checkOutput("b2b_ram_hold", ram_data_o, 32'h04030201);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
